// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline controller for the 16-bit datapath. It drives the PC write
//   enable, the IF/ID buffer enable and flush, and the ID/EX bubble. It
//   handles load-use stalls, taken-branch flushes, HALT and the global
//   memory-wait freeze.
//
//   Optional feature macro: PIPE_PERF_CNT_EN
//     defined   -> stall_cnt / flush_cnt are saturating counters
//     undefined -> both outputs are tied to zero and no counter flops exist
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   id_instr          IF/ID instruction (rs at [2R+1:R+1], rt at [R:0])
//   id_uses_rt        ID instruction reads rt
//   id_halt           ID instruction is HALT
//   ex_mem_read       EX instruction is a load
//   ex_rd             EX destination register
//   branch_taken      EX resolved a taken branch
//   mem_wait          memory not ready; freeze everything
//   resume            leave HALT
//   pc_en             PC write enable
//   ifid_en           IF/ID write enable
//   ifid_flush        clear IF/ID to NOP (wins over ifid_en downstream)
//   idex_bubble       insert NOP into ID/EX
//   state             FSM state (RUN=0, LSTALL=1, FLUSH=2, HALT=3)
//   stall_cnt         hazard-stall cycle count
//   flush_cnt         branch-flush event count
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | normal issue; detects branch, load-use hazard and HALT
// LSTALL | remaining load-use stall cycles (cnt of them left)
// FLUSH  | remaining post-branch flush cycles (cnt of them left)
// HALT   | frozen until resume
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int S         = 15,
    parameter int R         = 3,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1,
    parameter int CW        = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [S:0]    id_instr,
    input  logic          id_uses_rt,
    input  logic          id_halt,
    input  logic          ex_mem_read,
    input  logic [R:0]    ex_rd,
    input  logic          branch_taken,
    input  logic          mem_wait,
    input  logic          resume,
    output logic          pc_en,
    output logic          ifid_en,
    output logic          ifid_flush,
    output logic          idex_bubble,
    output logic [1:0]    state,
    output logic [CW:0]   stall_cnt,
    output logic [CW:0]   flush_cnt
);

    localparam int CMAX = (LOAD_LAT > FLUSH_CYC) ? LOAD_LAT : FLUSH_CYC;
    localparam int CNTW = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
    localparam logic [CNTW-1:0] LOAD_RELOAD  = CNTW'(LOAD_LAT - 1);
    localparam logic [CNTW-1:0] FLUSH_RELOAD = CNTW'(FLUSH_CYC - 1);
    localparam logic [CNTW-1:0] CNT_ONE      = CNTW'(1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t          st_q, st_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            stall_inc, flush_inc;

    logic [R:0] rs, rt;
    logic       hz;
    logic       unused_instr;

    assign rs = id_instr[2*R+1:R+1];
    assign rt = id_instr[R:0];
    assign unused_instr = ^id_instr[S:2*R+2];

    // Register 0 is hard-wired zero, so a load to it never creates a hazard.
    assign hz = ex_mem_read && (ex_rd != '0) &&
                ((ex_rd == rs) || (id_uses_rt && (ex_rd == rt)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= RUN;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-state logic; mem_wait leaves everything as-is
    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (!mem_wait) begin
            case (st_q)
                RUN: begin
                    if (branch_taken) begin
                        flush_inc = 1'b1;
                        if (FLUSH_CYC > 1) begin
                            st_d  = FLUSH;
                            cnt_d = FLUSH_RELOAD;
                        end
                    end else if (hz) begin
                        stall_inc = 1'b1;
                        if (LOAD_LAT > 1) begin
                            st_d  = LSTALL;
                            cnt_d = LOAD_RELOAD;
                        end
                    end else if (id_halt) begin
                        st_d = HALT;
                    end
                end
                LSTALL: begin
                    if (branch_taken) begin
                        flush_inc = 1'b1;
                        if (FLUSH_CYC > 1) begin
                            st_d  = FLUSH;
                            cnt_d = FLUSH_RELOAD;
                        end else begin
                            st_d  = RUN;
                            cnt_d = '0;
                        end
                    end else begin
                        stall_inc = 1'b1;
                        if (cnt_q <= CNT_ONE) begin
                            st_d  = RUN;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                FLUSH: begin
                    if (branch_taken) begin
                        flush_inc = 1'b1;
                        cnt_d     = FLUSH_RELOAD;
                    end else if (cnt_q <= CNT_ONE) begin
                        st_d  = RUN;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                HALT: begin
                    if (resume) begin
                        st_d = RUN;
                    end
                end
                default: begin
                    st_d  = RUN;
                    cnt_d = '0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        state       = st_q;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state       = RUN;
        end else if (mem_wait) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else begin
            case (st_q)
                RUN, LSTALL: begin
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (st_q == LSTALL || hz || id_halt) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                default: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CW:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters; stall_inc/flush_inc are already masked by mem_wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + (CW+1)'(1);
            if (flush_inc && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + (CW+1)'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = stall_inc ^ flush_inc;
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline controller for the 16-bit datapath.
- Sequences the IF/ID buffer, PC register and ID/EX buffer by generating write-enable, flush and bubble controls.
- Handles load-use stalls (multi-cycle load latency), taken-branch flushes, HALT, and a global memory-wait freeze.
- Sits beside the IF/ID buffer; its outputs drive that buffer's enable/flush and the PC write enable.

Parameters:
S, 15, instruction word MSB (word width S+1).
R, 3, register-address MSB (address width R+1).
LOAD_LAT, 1, load-use stall cycles (>=1).
FLUSH_CYC, 1, flush cycles after a taken branch (>=1).
CW, 15, performance counter MSB.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
id_instr  in  S+1  instruction currently in IF/ID; opcode [15:12], rd [11:8], rs [7:4], rt [3:0]
id_uses_rt  in  1  ID instruction reads rt
id_halt  in  1  ID instruction is HALT
ex_mem_read  in  1  EX-stage instruction is a load
ex_rd  in  R+1  EX-stage destination register
branch_taken  in  1  EX resolved a taken branch this cycle
mem_wait  in  1  memory not ready; freeze pipeline
resume  in  1  leave HALT
pc_en  out  1  PC write enable
ifid_en  out  1  IF/ID buffer write enable
ifid_flush  out  1  clear IF/ID to 16'h0000 (NOP)
idex_bubble  out  1  insert NOP into ID/EX
state  out  2  FSM state: RUN=0, LSTALL=1, FLUSH=2, HALT=3
stall_cnt  out  CW+1  hazard-stall cycle count
flush_cnt  out  CW+1  branch-flush event count

Behaviour:
- Storage: registered FSM, plus down-counter cnt (width fits max(LOAD_LAT, FLUSH_CYC)). Control outputs are combinational from state, cnt and inputs.
- rst=1, checked at the clock edge: next state RUN, cnt=0, perf counters=0.
- While rst=1, outputs are pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, state=0.
- Default (RUN, no event): pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- Load-use hazard: hz = ex_mem_read & (ex_rd!=0) & (ex_rd==rs | (id_uses_rt & ex_rd==rt)). Register 0 never hazards.
- Priority per cycle: mem_wait > branch_taken > hz > id_halt.
- mem_wait=1, any state:
  - pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0.
  - state, cnt and counters hold.
  - EX holds branch_taken stable across the wait.
- RUN + branch_taken:
  - pc_en=1 (load target), ifid_flush=1, idex_bubble=1, flush_cnt+1.
  - FLUSH_CYC=1: stay RUN. Else go to FLUSH with cnt=FLUSH_CYC-1.
- RUN + hz:
  - pc_en=0, ifid_en=0, idex_bubble=1, stall_cnt+1.
  - LOAD_LAT=1: stay RUN. Else go to LSTALL with cnt=LOAD_LAT-1.
- RUN + id_halt:
  - pc_en=0, ifid_en=0, idex_bubble=1; go to HALT.
- LSTALL:
  - Outputs as for hz; stall_cnt+1; cnt-1.
  - When cnt reaches 1, go to RUN on the next edge.
  - branch_taken in LSTALL overrides: flush behaviour, next state per FLUSH rule.
- FLUSH:
  - pc_en=1, ifid_flush=1, idex_bubble=1; cnt-1.
  - At cnt=1, go to RUN.
  - A new branch_taken reloads cnt=FLUSH_CYC-1 and increments flush_cnt.
- HALT:
  - pc_en=0, ifid_en=0, idex_bubble=1.
  - resume=1: go to RUN next cycle. resume is ignored in other states.
  - branch_taken in HALT is ignored.
- Counters saturate at all-ones (no wrap).
- ifid_flush has priority over ifid_en in the downstream buffer.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: stall_cnt and flush_cnt registers are implemented as described above.
- Undefined: both outputs are tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles, then 0 -> during reset pc_en=0, ifid_flush=1, idex_bubble=1; after release state=0, pc_en=1, ifid_en=1, counters=0.
- LOAD_LAT=2, ex_mem_read=1, ex_rd=4'h3, id_instr=16'h1230 (rs=3) -> 2 cycles pc_en=0/idex_bubble=1, state 0->1->0, stall_cnt=2. Same with ex_rd=0 -> no stall.
- FLUSH_CYC=2, branch_taken pulse with hz also high -> flush wins: ifid_flush=1 for 2 cycles, pc_en=1, flush_cnt=1, stall_cnt=0.
- mem_wait=1 for 3 cycles in the middle of LSTALL -> all enables 0, state/cnt frozen, then remaining stall completes; stall_cnt excludes wait cycles.
- id_halt=1 -> state=3, pc_en=0; branch_taken in HALT ignored; resume=1 -> state=0 next cycle.
- Force stall_cnt to all-ones via a long hz sequence (CW=3: 20 stall cycles) -> stall_cnt holds 4'hF; rst mid-LSTALL -> state=0 and counters=0 next cycle.
